// File: rtl/ex_operand_issue.sv
// ---------------------------------------------------------------------------
// ex_operand_issue
//
// ID/EX pipeline register plus the operand bypass network that feeds the ALU.
// Decoded operands captured from ID are held in the EX stage register. Each
// cycle they are patched with the freshest values from the EX/MEM and MEM/WB
// bypass paths and presented to the ALU as lvalue/rvalue/alu_op. A load
// sitting in EX whose destination is needed by the instruction in ID raises
// id_stall_req. ID/IF must then hold, and a bubble is inserted into EX.
//
// Ports
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   id_*                  decoded instruction fields from the ID stage
//   ex_hold               downstream stall, EX register keeps its contents
//   ex_flush              branch flush, EX register loads a bubble
//   mem_fwd_*             EX/MEM bypass (write enable, index, ALU result)
//   wb_fwd_*              MEM/WB bypass (write enable, index, write data)
//   alu_lvalue/rvalue/op  operands and opcode driven to the ALU
//   ex_valid, ex_rd_idx,
//   ex_reg_write          EX-stage bookkeeping for the later stages
//   ex_store_data         forwarded rt value for stores
//   id_stall_req          load-use hazard detected, ID/IF must hold
// ---------------------------------------------------------------------------
module ex_operand_issue #(
  parameter int              WIDTH  = 32,
  parameter int              OP_W   = 4,
  parameter int              IDX_W  = 5,
  parameter logic [OP_W-1:0] NOP_OP = 4'h0
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             id_valid,
  input  logic [WIDTH-1:0] id_rs_data,
  input  logic [WIDTH-1:0] id_rt_data,
  input  logic [WIDTH-1:0] id_imm,
  input  logic [IDX_W-1:0] id_rs_idx,
  input  logic [IDX_W-1:0] id_rt_idx,
  input  logic [IDX_W-1:0] id_rd_idx,
  input  logic [OP_W-1:0]  id_alu_op,
  input  logic             id_alu_src,
  input  logic             id_reg_write,
  input  logic             id_mem_read,

  input  logic             ex_hold,
  input  logic             ex_flush,

  input  logic             mem_fwd_we,
  input  logic [IDX_W-1:0] mem_fwd_idx,
  input  logic [WIDTH-1:0] mem_fwd_data,
  input  logic             wb_fwd_we,
  input  logic [IDX_W-1:0] wb_fwd_idx,
  input  logic [WIDTH-1:0] wb_fwd_data,

  output logic [WIDTH-1:0] alu_lvalue,
  output logic [WIDTH-1:0] alu_rvalue,
  output logic [OP_W-1:0]  alu_op,
  output logic             ex_valid,
  output logic [IDX_W-1:0] ex_rd_idx,
  output logic             ex_reg_write,
  output logic [WIDTH-1:0] ex_store_data,
  output logic             id_stall_req
);

  // EX stage register contents
  logic             valid_q;
  logic [WIDTH-1:0] rs_data_q;
  logic [WIDTH-1:0] rt_data_q;
  logic [WIDTH-1:0] imm_q;
  logic [IDX_W-1:0] rs_idx_q;
  logic [IDX_W-1:0] rt_idx_q;
  logic [IDX_W-1:0] rd_idx_q;
  logic [OP_W-1:0]  alu_op_q;
  logic             alu_src_q;
  logic             reg_write_q;
  logic             mem_read_q;

  // Stage register control and forwarded operands
  logic             load_bubble;
  logic             load_id;
  logic             load_use_hit;
  logic [WIDTH-1:0] rs_fwd;
  logic [WIDTH-1:0] rt_fwd;

  // Load-use hazard: the load in EX produces its data too late for the
  // instruction in ID. rt only matters when ID actually reads it (alu_src=0).
  // r0 is never a real dependency.
  always_comb begin
    load_use_hit = 1'b0;
    if (valid_q && mem_read_q && (rd_idx_q != '0) && id_valid) begin
      load_use_hit = (rd_idx_q == id_rs_idx) ||
                     ((rd_idx_q == id_rt_idx) && !id_alu_src);
    end
  end

  assign id_stall_req = load_use_hit;

  // Update priority: flush beats hold, and hold beats the stall bubble.
  // During a hold with a pending hazard the register keeps the load while
  // id_stall_req stays high, so ID also waits.
  always_comb begin
    load_bubble = ex_flush || (!ex_hold && id_stall_req);
    load_id     = !ex_hold;
  end

  // EX stage register. A bubble clears every field so that nothing stale
  // can be forwarded or written back from an empty slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      rs_idx_q    <= '0;
      rt_idx_q    <= '0;
      rd_idx_q    <= '0;
      alu_op_q    <= NOP_OP;
      alu_src_q   <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
    end else if (load_bubble) begin
      valid_q     <= 1'b0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      rs_idx_q    <= '0;
      rt_idx_q    <= '0;
      rd_idx_q    <= '0;
      alu_op_q    <= NOP_OP;
      alu_src_q   <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
    end else if (load_id) begin
      valid_q     <= id_valid;
      rs_data_q   <= id_rs_data;
      rt_data_q   <= id_rt_data;
      imm_q       <= id_imm;
      rs_idx_q    <= id_rs_idx;
      rt_idx_q    <= id_rt_idx;
      rd_idx_q    <= id_rd_idx;
      alu_op_q    <= id_alu_op;
      alu_src_q   <= id_alu_src;
      reg_write_q <= id_reg_write;
      mem_read_q  <= id_mem_read;
    end
  end

  // rs bypass: the younger EX/MEM result wins over MEM/WB. Index 0 is
  // hardwired zero and is never overridden by a bypass.
  always_comb begin
    rs_fwd = rs_data_q;
    if (rs_idx_q != '0) begin
      if (mem_fwd_we && (mem_fwd_idx == rs_idx_q)) begin
        rs_fwd = mem_fwd_data;
      end else if (wb_fwd_we && (wb_fwd_idx == rs_idx_q)) begin
        rs_fwd = wb_fwd_data;
      end
    end
  end

  // rt bypass, same rules as rs. Stores consume this value even when the
  // ALU takes the immediate instead.
  always_comb begin
    rt_fwd = rt_data_q;
    if (rt_idx_q != '0) begin
      if (mem_fwd_we && (mem_fwd_idx == rt_idx_q)) begin
        rt_fwd = mem_fwd_data;
      end else if (wb_fwd_we && (wb_fwd_idx == rt_idx_q)) begin
        rt_fwd = wb_fwd_data;
      end
    end
  end

  // ALU drive. Bubbles present zero operands and the NOP opcode, so the
  // bypass network never leaks values into an empty slot.
  always_comb begin
    alu_lvalue = '0;
    alu_rvalue = '0;
    alu_op     = NOP_OP;
    if (valid_q) begin
      alu_lvalue = rs_fwd;
      alu_rvalue = alu_src_q ? imm_q : rt_fwd;
      alu_op     = alu_op_q;
    end
  end

  assign ex_valid      = valid_q;
  assign ex_rd_idx     = rd_idx_q;
  assign ex_reg_write  = valid_q && reg_write_q;
  assign ex_store_data = rt_fwd;

endmodule

// File: tb/tb_ex_operand_issue.sv
// ---------------------------------------------------------------------------
// tb_ex_operand_issue
//
// Self-checking bench for ex_operand_issue. A behavioural model of the EX slot
// tracks what the stage should hold, and the expected ALU-side outputs are
// derived from it. The directed scenarios come first. A randomized stream
// with forced register collisions follows them.
// ---------------------------------------------------------------------------
module tb_ex_operand_issue;

  localparam int         WIDTH  = 32;
  localparam int         OP_W   = 4;
  localparam int         IDX_W  = 5;
  localparam logic [3:0] NOP_OP = 4'h0;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             id_valid, id_alu_src, id_reg_write, id_mem_read;
  logic [WIDTH-1:0] id_rs_data, id_rt_data, id_imm;
  logic [IDX_W-1:0] id_rs_idx, id_rt_idx, id_rd_idx;
  logic [OP_W-1:0]  id_alu_op;
  logic             ex_hold, ex_flush;
  logic             mem_fwd_we, wb_fwd_we;
  logic [IDX_W-1:0] mem_fwd_idx, wb_fwd_idx;
  logic [WIDTH-1:0] mem_fwd_data, wb_fwd_data;
  logic [WIDTH-1:0] alu_lvalue, alu_rvalue, ex_store_data;
  logic [OP_W-1:0]  alu_op;
  logic             ex_valid, ex_reg_write, id_stall_req;
  logic [IDX_W-1:0] ex_rd_idx;

  ex_operand_issue #(.WIDTH(WIDTH), .OP_W(OP_W), .IDX_W(IDX_W), .NOP_OP(NOP_OP)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_rs_idx(id_rs_idx), .id_rt_idx(id_rt_idx),
    .id_rd_idx(id_rd_idx), .id_alu_op(id_alu_op), .id_alu_src(id_alu_src),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .ex_hold(ex_hold), .ex_flush(ex_flush),
    .mem_fwd_we(mem_fwd_we), .mem_fwd_idx(mem_fwd_idx), .mem_fwd_data(mem_fwd_data),
    .wb_fwd_we(wb_fwd_we), .wb_fwd_idx(wb_fwd_idx), .wb_fwd_data(wb_fwd_data),
    .alu_lvalue(alu_lvalue), .alu_rvalue(alu_rvalue), .alu_op(alu_op),
    .ex_valid(ex_valid), .ex_rd_idx(ex_rd_idx), .ex_reg_write(ex_reg_write),
    .ex_store_data(ex_store_data), .id_stall_req(id_stall_req)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          valid;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs_idx;
    logic [4:0]  rt_idx;
    logic [4:0]  rd_idx;
    logic [3:0]  op;
    bit          alu_src;
    bit          reg_write;
    bit          mem_read;
  } slot_t;

  slot_t m;
  slot_t bubble;
  int    checks = 0;
  int    fails  = 0;

  // Single comparison point: counts the check and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  function automatic slot_t instr(input bit v, input logic [4:0] rs, input logic [31:0] rsd,
                                  input logic [4:0] rt, input logic [31:0] rtd,
                                  input logic [4:0] rd, input logic [3:0] op, input bit src,
                                  input logic [31:0] imm, input bit rw, input bit mr);
    slot_t s;
    s.valid = v; s.rs_idx = rs; s.rs_data = rsd; s.rt_idx = rt; s.rt_data = rtd;
    s.rd_idx = rd; s.op = op; s.alu_src = src; s.imm = imm; s.reg_write = rw; s.mem_read = mr;
    return s;
  endfunction

  // Drives one ID instruction plus the EX control inputs.
  task automatic applyStimulus(input slot_t s, input bit hold, input bit flush);
    id_valid = s.valid; id_rs_idx = s.rs_idx; id_rs_data = s.rs_data;
    id_rt_idx = s.rt_idx; id_rt_data = s.rt_data; id_rd_idx = s.rd_idx;
    id_alu_op = s.op; id_alu_src = s.alu_src; id_imm = s.imm;
    id_reg_write = s.reg_write; id_mem_read = s.mem_read;
    ex_hold = hold; ex_flush = flush;
  endtask

  task automatic setFwd(input bit mwe, input logic [4:0] midx, input logic [31:0] md,
                        input bit wwe, input logic [4:0] widx, input logic [31:0] wd);
    mem_fwd_we = mwe; mem_fwd_idx = midx; mem_fwd_data = md;
    wb_fwd_we = wwe; wb_fwd_idx = widx; wb_fwd_data = wd;
  endtask

  // Value a source register should read, given the current bypass inputs.
  function automatic logic [31:0] srcValue(input logic [4:0] idx, input logic [31:0] regval);
    if (idx == 5'd0) return regval;
    if (mem_fwd_we && mem_fwd_idx == idx) return mem_fwd_data;
    if (wb_fwd_we && wb_fwd_idx == idx) return wb_fwd_data;
    return regval;
  endfunction

  function automatic bit expStall();
    if (!(m.valid && m.mem_read && m.rd_idx != 5'd0 && id_valid)) return 1'b0;
    return (m.rd_idx == id_rs_idx) || (m.rd_idx == id_rt_idx && !id_alu_src);
  endfunction

  task automatic checkAll(input string tag);
    checkOutput({tag, "/valid"}, 32'(ex_valid), 32'(m.valid));
    checkOutput({tag, "/lvalue"}, alu_lvalue, m.valid ? srcValue(m.rs_idx, m.rs_data) : 32'd0);
    checkOutput({tag, "/rvalue"}, alu_rvalue,
                m.valid ? (m.alu_src ? m.imm : srcValue(m.rt_idx, m.rt_data)) : 32'd0);
    checkOutput({tag, "/op"}, 32'(alu_op), 32'(m.valid ? m.op : NOP_OP));
    checkOutput({tag, "/rd"}, 32'(ex_rd_idx), 32'(m.rd_idx));
    checkOutput({tag, "/regwr"}, 32'(ex_reg_write), 32'(m.valid && m.reg_write));
    checkOutput({tag, "/store"}, ex_store_data, srcValue(m.rt_idx, m.rt_data));
    checkOutput({tag, "/stall"}, 32'(id_stall_req), 32'(expStall()));
  endtask

  // Model of the EX slot at a rising edge, using the inputs present at that edge.
  task automatic modelEdge();
    bit st;
    st = expStall();
    if (!rst_n || ex_flush) m = bubble;
    else if (ex_hold) m = m;
    else if (st) m = bubble;
    else begin
      m = instr(id_valid, id_rs_idx, id_rs_data, id_rt_idx, id_rt_data, id_rd_idx,
                id_alu_op, id_alu_src, id_imm, id_reg_write, id_mem_read);
    end
  endtask

  task automatic cycle(input string tag);
    #1;
    checkAll(tag);
    @(posedge clk);
    modelEdge();
    @(negedge clk);
  endtask

  slot_t nop, s;

  initial begin
    bubble = instr(0, 0, 0, 0, 0, 0, NOP_OP, 0, 0, 0, 0);
    nop = bubble;
    m = bubble;
    applyStimulus(nop, 0, 0);
    setFwd(0, 0, 0, 0, 0, 0);

    // Reset state
    #1;
    checkOutput("rst/valid", 32'(ex_valid), 32'd0);
    checkOutput("rst/op", 32'(alu_op), 32'(NOP_OP));
    checkOutput("rst/lvalue", alu_lvalue, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // add r3 = r1(5) + r2(7)
    applyStimulus(instr(1, 1, 5, 2, 7, 3, 4'h2, 0, 0, 1, 0), 0, 0);
    cycle("add_cap");
    applyStimulus(nop, 0, 0);
    #1;
    checkOutput("add/lvalue", alu_lvalue, 32'd5);
    checkOutput("add/rvalue", alu_rvalue, 32'd7);
    checkOutput("add/op", 32'(alu_op), 32'h2);
    cycle("add_ex");

    // Bypass priority on rs=r4, with EX frozen by hold
    applyStimulus(instr(1, 4, 32'h99, 6, 32'h66, 7, 4'h3, 0, 0, 1, 0), 0, 0);
    cycle("fwd_cap");
    applyStimulus(nop, 1, 0);
    setFwd(1, 4, 32'h11, 1, 4, 32'h22);
    #1;
    checkOutput("fwd/mem", alu_lvalue, 32'h11);
    setFwd(0, 4, 32'h11, 1, 4, 32'h22);
    #1;
    checkOutput("fwd/wb", alu_lvalue, 32'h22);
    cycle("fwd_hold");
    setFwd(0, 0, 0, 0, 0, 0);

    // r0 is never forwarded
    applyStimulus(instr(1, 0, 0, 2, 7, 8, 4'h1, 0, 0, 1, 0), 0, 0);
    cycle("r0_cap");
    applyStimulus(nop, 0, 0);
    setFwd(1, 0, 32'hFFFF_FFFF, 1, 0, 32'hFFFF_FFFF);
    #1;
    checkOutput("r0/lvalue", alu_lvalue, 32'd0);
    cycle("r0_ex");
    setFwd(0, 0, 0, 0, 0, 0);

    // Load-use: lw r5 in EX, add using r5 in ID
    applyStimulus(instr(1, 1, 32'h100, 0, 0, 5, 4'h0, 1, 32'h4, 1, 1), 0, 0);
    cycle("lw_cap");
    applyStimulus(instr(1, 5, 32'h55, 2, 7, 9, 4'h2, 0, 0, 1, 0), 0, 0);
    #1;
    checkOutput("lu/stall", 32'(id_stall_req), 32'd1);
    cycle("lu_hazard");
    #1;
    checkOutput("lu/bubble_valid", 32'(ex_valid), 32'd0);
    checkOutput("lu/stall_clear", 32'(id_stall_req), 32'd0);
    cycle("lu_bubble");
    applyStimulus(nop, 0, 0);
    cycle("lu_issue");

    // flush beats hold; hold alone freezes
    applyStimulus(instr(1, 2, 32'h20, 3, 32'h30, 4, 4'h5, 0, 0, 1, 0), 0, 0);
    cycle("fh_cap");
    applyStimulus(instr(1, 6, 32'h60, 7, 32'h70, 8, 4'h6, 0, 0, 1, 0), 1, 1);
    cycle("fh_flush");
    #1;
    checkOutput("fh/bubble", 32'(ex_valid), 32'd0);
    applyStimulus(instr(1, 2, 32'h20, 3, 32'h30, 4, 4'h5, 0, 0, 1, 0), 0, 0);
    cycle("fh_load");
    applyStimulus(instr(1, 6, 32'h60, 7, 32'h70, 8, 4'h6, 0, 0, 1, 0), 1, 0);
    cycle("fh_hold");
    #1;
    checkOutput("hold/op", 32'(alu_op), 32'h5);
    checkOutput("hold/lvalue", alu_lvalue, 32'h20);

    // Asynchronous reset while EX is valid
    checkOutput("mrst/pre_valid", 32'(ex_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mrst/valid", 32'(ex_valid), 32'd0);
    checkOutput("mrst/op", 32'(alu_op), 32'(NOP_OP));
    m = bubble;
    applyStimulus(nop, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized stream, small index range to provoke collisions
    for (int i = 0; i < 400; i++) begin
      s.valid     = ($urandom_range(0, 9) < 8);
      s.rs_idx    = 5'($urandom_range(0, 7));
      s.rt_idx    = 5'($urandom_range(0, 7));
      s.rd_idx    = 5'($urandom_range(0, 7));
      s.rs_data   = (s.rs_idx == 0) ? 32'd0 : $urandom();
      s.rt_data   = (s.rt_idx == 0) ? 32'd0 : $urandom();
      s.imm       = $urandom();
      s.op        = 4'($urandom_range(0, 15));
      s.alu_src   = $urandom_range(0, 1) == 1;
      s.reg_write = $urandom_range(0, 1) == 1;
      s.mem_read  = ($urandom_range(0, 9) < 3);
      applyStimulus(s, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
      setFwd($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom(),
             $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom());
      cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
